npc_seq_ctrl: RTL

- Multi-cycle sequencer for the NPC RV32 datapath (PC, register file, ALU, decode/control unit).
- Replaces the free-running "fetch every clock" behaviour with an explicit FSM:
  - fetches each instruction over a valid/ready instruction-memory handshake;
  - runs the data-memory handshake for loads and stores;
  - gates PC and register-file write enables so architectural state updates exactly once per retired instruction.
- Also detects ebreak halt and memory-response timeout.

---
 rtl/npc_seq_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/npc_seq_ctrl.sv
// Multi-cycle sequencer for the NPC RV32 core: fetch/data-memory handshakes,
// once-per-instruction PC/RF write strobes, ebreak halt and response timeout.
module npc_seq_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    input  logic             imem_resp_valid,
    input  logic [31:0]      imem_resp_data,
    output logic [31:0]      inst,
    output logic             inst_valid,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_wreg,
    input  logic             dec_ebreak,
    output logic             dmem_req_valid,
    output logic             dmem_req_we,
    input  logic             dmem_req_ready,
    input  logic             dmem_resp_valid,
    output logic             pc_wen,
    output logic             rf_wen,
    output logic             halt,
    output logic             err,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        FETCH = 4'd1,
        FWAIT = 4'd2,
        EXEC  = 4'd3,
        MEM   = 4'd4,
        MWAIT = 4'd5,
        WB    = 4'd6,
        HALT  = 4'd7,
        ERR   = 4'd8
    } state_t;

    // Last wait-cycle index before a missing response is declared a timeout.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [31:0]      inst_q, inst_d;
    logic             st_q, st_d;
    logic             wreg_q, wreg_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            inst_q    <= '0;
            st_q      <= 1'b0;
            wreg_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            inst_q    <= inst_d;
            st_q      <= st_d;
            wreg_q    <= wreg_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        inst_d         = inst_q;
        st_d           = st_q;
        wreg_d         = wreg_q;
        retired_d      = retired_q;
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        dmem_req_valid = 1'b0;
        dmem_req_we    = 1'b0;
        pc_wen         = 1'b0;
        rf_wen         = 1'b0;
        halt           = 1'b0;
        err            = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    state_d = FWAIT;
                    cnt_d   = '0;
                end
            end
            FWAIT: begin
                if (imem_resp_valid) begin
                    inst_d  = imem_resp_data;
                    state_d = EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            EXEC: begin
                inst_valid = 1'b1;
                // A load+store decode collapses to a store.
                st_d       = dec_store;
                wreg_d     = dec_wreg;
                if (dec_ebreak)                 state_d = HALT;
                else if (dec_load || dec_store) state_d = MEM;
                else                            state_d = WB;
            end
            MEM: begin
                inst_valid     = 1'b1;
                dmem_req_valid = 1'b1;
                dmem_req_we    = st_q;
                if (dmem_req_ready) begin
                    state_d = MWAIT;
                    cnt_d   = '0;
                end
            end
            MWAIT: begin
                inst_valid = 1'b1;
                if (dmem_resp_valid) begin
                    state_d = WB;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WB: begin
                inst_valid = 1'b1;
                pc_wen     = 1'b1;
                rf_wen     = wreg_q & ~st_q;
                retired_d  = retired_q + CNT_W'(1);
                state_d    = FETCH;
            end
            HALT: halt = 1'b1;
            ERR: begin
                halt = 1'b1;
                err  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state   = state_q;
    assign inst    = inst_q;
    assign retired = retired_q;

endmodule
